// File: rtl/s27_stim_driver.sv
// Built-in stimulus driver for the ISCAS s27 circuit: applies an init vector,
// then an LFSR vector sequence, compacting the G17 response into a 16-bit MISR.
module s27_stim_driver #(
  parameter int unsigned NUM_PATTERNS = 64,
  parameter int unsigned INIT_CYCLES  = 3,
  parameter logic [7:0]  SEED         = 8'h01,
  parameter logic [15:0] GOLDEN       = 16'h0000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic        G17,
  output logic        G0,
  output logic        G1,
  output logic        G2,
  output logic        G3,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  // An all-zero LFSR would lock up, so a zero seed falls back to 8'h01.
  localparam logic [7:0]  SEED_EFF    = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [7:0]  INIT_LAST   = 8'(INIT_CYCLES - 1);
  localparam logic [15:0] NUM_PAT     = 16'(NUM_PATTERNS);
  localparam bit          NO_PATTERNS = (NUM_PATTERNS == 0);
  localparam logic [3:0]  INIT_VEC    = 4'b0101;

  state_e      state_q, state_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [15:0] sig_q, sig_d;
  logic [7:0]  init_cnt_q, init_cnt_d;
  logic [15:0] pat_cnt_q, pat_cnt_d;
  logic [3:0]  g_q, g_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    sig_d      = sig_q;
    init_cnt_d = init_cnt_q;
    pat_cnt_d  = pat_cnt_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = INIT;
          lfsr_d     = SEED_EFF;
          sig_d      = 16'h0000;
          init_cnt_d = 8'h00;
          pat_cnt_d  = 16'h0000;
        end
      end
      INIT: begin
        init_cnt_d = init_cnt_q + 8'h01;
        if (init_cnt_q == INIT_LAST) begin
          state_d = NO_PATTERNS ? DONE : RUN;
        end
      end
      RUN: begin
        // The response captured here belongs to the vector currently on G0..G3.
        sig_d     = {sig_q[14:0], 1'b0}
                  ^ (sig_q[15] ? 16'h1021 : 16'h0000)
                  ^ {15'b0, G17};
        lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        pat_cnt_d = pat_cnt_q + 16'h0001;
        if (pat_cnt_d == NUM_PAT) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state values, so G0..G3 never see an input combinationally.
  always_comb begin
    g_d    = 4'b0000;
    busy_d = 1'b0;
    done_d = 1'b0;
    unique case (state_d)
      INIT: begin
        g_d    = INIT_VEC;
        busy_d = 1'b1;
      end
      RUN: begin
        g_d    = lfsr_d[3:0];
        busy_d = 1'b1;
      end
      DONE:    done_d = 1'b1;
      default: g_d    = 4'b0000;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      lfsr_q     <= 8'h01;
      sig_q      <= 16'h0000;
      init_cnt_q <= 8'h00;
      pat_cnt_q  <= 16'h0000;
      g_q        <= 4'b0000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of its peers.
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      sig_q      <= sig_d;
      init_cnt_q <= init_cnt_d;
      pat_cnt_q  <= pat_cnt_d;
      g_q        <= g_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign {G3, G2, G1, G0} = g_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = done_q && (sig_q == GOLDEN);
  assign signature        = sig_q;

endmodule

// File: tb/tb_s27_stim_driver.sv
// Self-checking bench: several parameterisations of s27_stim_driver run side by side
// against a phase/position model plus hand-computed expectations.
module tb_s27_stim_driver;

  localparam int NI = 5;
  localparam int unsigned NP [NI] = '{4, 4, 0, 37, 50};
  localparam int unsigned IC [NI] = '{3, 3, 3, 5, 1};
  localparam logic [7:0]  SD [NI] = '{8'h01, 8'h01, 8'h01, 8'h00, 8'hA7};
  localparam logic [15:0] GD [NI] = '{16'h000F, 16'h0000, 16'h0000, 16'h1234, 16'h0000};

  // Hand-computed view of instance 0 after edges 1..8 following the accepted start.
  localparam logic [3:0]  EXP_G [8] = '{4'h5, 4'h5, 4'h5, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
  localparam logic [15:0] EXP_S [8] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000,
                                        16'h0001, 16'h0003, 16'h0007, 16'h000F};

  logic                  clock;
  logic                  resetn;
  logic                  start;
  logic [NI-1:0]         g17;
  logic [NI-1:0][3:0]    g_w;
  logic [NI-1:0]         busy_w;
  logic [NI-1:0]         done_w;
  logic [NI-1:0]         pass_w;
  logic [NI-1:0][15:0]   sig_w;

  int checks;
  int errors;

  // Model: edges since the accepted start determine the phase; MISR holds absorbed responses.
  bit          act  [NI];
  int          k    [NI];
  logic [15:0] msig [NI];

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    s27_stim_driver #(
      .NUM_PATTERNS (NP[gi]),
      .INIT_CYCLES  (IC[gi]),
      .SEED         (SD[gi]),
      .GOLDEN       (GD[gi])
    ) u_dut (
      .clock     (clock),
      .resetn    (resetn),
      .start     (start),
      .G17       (g17[gi]),
      .G0        (g_w[gi][0]),
      .G1        (g_w[gi][1]),
      .G2        (g_w[gi][2]),
      .G3        (g_w[gi][3]),
      .busy      (busy_w[gi]),
      .done      (done_w[gi]),
      .pass      (pass_w[gi]),
      .signature (sig_w[gi])
    );
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int inst, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, inst, $time, got, exp);
    end
  endtask

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic b);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'b0, b};
  endfunction

  function automatic logic [7:0] lfsr_at(input int i, input int p);
    logic [7:0] l;
    l = (SD[i] == 8'h00) ? 8'h01 : SD[i];
    for (int n = 0; n < p; n++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    return l;
  endfunction

  // 0 idle, 1 init, 2 run, 3 done
  function automatic int phase_of(input int i);
    if (!act[i]) return 0;
    if (k[i] <= int'(IC[i])) return 1;
    if (k[i] <= int'(IC[i] + NP[i])) return 2;
    return 3;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      act[i]  = 1'b0;
      k[i]    = 0;
      msig[i] = 16'h0000;
    end
  endtask

  task automatic model_edge();
    int ph;
    if (!resetn) return;
    for (int i = 0; i < NI; i++) begin
      ph = phase_of(i);
      if (ph == 2) msig[i] = misr_step(msig[i], g17[i]);
      if (ph == 1 || ph == 2) k[i]++;
      if ((ph == 0 || ph == 3) && start) begin
        act[i]  = 1'b1;
        k[i]    = 1;
        msig[i] = 16'h0000;
      end
    end
  endtask

  task automatic compare_all();
    int         ph;
    logic [3:0] eg;
    logic [7:0] l;
    for (int i = 0; i < NI; i++) begin
      ph = phase_of(i);
      eg = 4'h0;
      if (ph == 1) eg = 4'b0101;
      if (ph == 2) begin
        l  = lfsr_at(i, k[i] - int'(IC[i]) - 1);
        eg = l[3:0];
      end
      check("g_vec", i, 32'(g_w[i]), 32'(eg));
      check("busy", i, 32'(busy_w[i]), 32'(ph == 1 || ph == 2));
      check("done", i, 32'(done_w[i]), 32'(ph == 3));
      check("pass", i, 32'(pass_w[i]), 32'(ph == 3 && msig[i] == GD[i]));
      check("signature", i, 32'(sig_w[i]), 32'(msig[i]));
    end
  endtask

  task automatic tick();
    @(negedge clock);
    compare_all();
    @(posedge clock);
    model_edge();
    #2;
  endtask

  task automatic check_zero(input int i);
    check("rst_g_vec", i, 32'(g_w[i]), 32'h0);
    check("rst_busy", i, 32'(busy_w[i]), 32'h0);
    check("rst_done", i, 32'(done_w[i]), 32'h0);
    check("rst_pass", i, 32'(pass_w[i]), 32'h0);
    check("rst_signature", i, 32'(sig_w[i]), 32'h0);
  endtask

  // Pulse start with G17 stuck at one value; pin instances 0..2 against literals.
  task automatic pinned_run(input bit stuck);
    g17   = stuck ? '1 : '0;
    start = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      tick();
      start = 1'b0;
      check("pin_g_vec", 0, 32'(g_w[0]), 32'(EXP_G[j-1]));
      check("pin_signature", 0, 32'(sig_w[0]), stuck ? 32'(EXP_S[j-1]) : 32'h0);
      check("pin_busy", 0, 32'(busy_w[0]), 32'(j < 8));
      check("pin_done", 0, 32'(done_w[0]), 32'(j == 8));
      if (j == 4) begin
        check("pin_zero_done", 2, 32'(done_w[2]), 32'h1);
        check("pin_zero_sig", 2, 32'(sig_w[2]), 32'h0);
        check("pin_zero_pass", 2, 32'(pass_w[2]), 32'h1);
      end
    end
    check("pin_pass_gold_f", 0, 32'(pass_w[0]), stuck ? 32'h1 : 32'h0);
    check("pin_pass_gold_0", 1, 32'(pass_w[1]), stuck ? 32'h0 : 32'h1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    start  = 1'b0;
    g17    = '0;
    resetn = 1'b1;
    model_reset();
    #1 resetn = 1'b0;
    #2;
    for (int i = 0; i < NI; i++) check_zero(i);
    tick();
    tick();
    resetn = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("idle_busy", 0, 32'(busy_w[0]), 32'h0);
      check("idle_g_vec", 0, 32'(g_w[0]), 32'h0);
    end

    pinned_run(1'b0);
    pinned_run(1'b1);

    // Start held high while DONE: new run with cleared MISR, start ignored in INIT.
    g17   = '1;
    start = 1'b1;
    tick();
    check("restart_sig", 0, 32'(sig_w[0]), 32'h0);
    check("restart_busy", 0, 32'(busy_w[0]), 32'h1);
    tick();
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("restart_done", 0, 32'(done_w[0]), 32'h1);
    check("restart_final_sig", 0, 32'(sig_w[0]), 32'h000F);

    // Reset asserted asynchronously during the second RUN cycle.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("midrun_g_vec", 0, 32'(g_w[0]), 32'h2);
    check("midrun_sig", 0, 32'(sig_w[0]), 32'h0001);
    resetn = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < NI; i++) check_zero(i);
    tick();
    resetn = 1'b1;
    repeat (3) begin
      tick();
      check("post_reset_idle", 0, 32'(busy_w[0]), 32'h0);
    end
    pinned_run(1'b1);

    // Randomised traffic with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      start = ($urandom_range(0, 7) == 0);
      g17   = NI'($urandom);
      if ($urandom_range(0, 599) == 0) begin
        resetn = 1'b0;
        model_reset();
        tick();
        resetn = 1'b1;
      end else begin
        tick();
      end
    end
    start = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
